// File: rtl/multicycle_alu_pkg.sv
// multicycle_alu_pkg: shared ALU select codes, shamt width and FSM state type
package multicycle_alu_pkg;
  localparam int SHAMT_W = 5;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/multicycle_alu_shift_step.sv
// alu_shift_step: combinational one-bit left/right logical/arithmetic shifter
module alu_shift_step (
  input  logic [31:0] d,
  input  logic        left,
  input  logic        arith,
  output logic [31:0] q
);
  assign q = left ? {d[30:0], 1'b0} : {arith & d[31], d[31:1]};
endmodule

// File: rtl/multicycle_alu.sv
// multicycle_alu: single-cycle ALU ops plus bit-serial shifts with flush and registered flags
module multicycle_alu
  import multicycle_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        out_valid,
  output logic        zero,
  output logic        neg,
  output logic        carry,
  output logic        ovf,
  output logic        busy
);
  state_t state, state_nxt;
  logic [SHAMT_W-1:0] cnt;
  logic [31:0] sh_val, sh_nxt, op_res;
  logic [32:0] add_w, sub_w;
  logic sh_left, sh_arith, op_z, op_c, op_v, is_shift, accept, start_shift, last_step;
  alu_shift_step u_step (
    .d     (sh_val),
    .left  (sh_left),
    .arith (sh_arith),
    .q     (sh_nxt)
  );
  assign busy     = state == SHIFT;
  assign in_ready = ~busy;
  always_comb begin
    add_w       = {1'b0, a} + {1'b0, b};
    sub_w       = {1'b0, a} - {1'b0, b};
    is_shift    = alu_sel == ALU_SLL || alu_sel == ALU_SRL || alu_sel == ALU_SRA;
    accept      = in_valid & ~busy & ~flush;
    start_shift = accept & is_shift & (b[SHAMT_W-1:0] != '0);
    last_step   = busy & (cnt == SHAMT_W'(1));
    state_nxt   = flush ? IDLE : start_shift ? SHIFT : last_step ? IDLE : state;
  end
  always_comb begin
    op_res = '0;
    op_c   = 1'b0;
    op_v   = 1'b0;
    case (alu_sel)
      ALU_ADD: begin
        op_res = add_w[31:0];
        op_c   = add_w[32];
        op_v   = (a[31] == b[31]) & (add_w[31] != a[31]);
      end
      ALU_SUB: begin
        op_res = sub_w[31:0];
        op_c   = ~sub_w[32];
        op_v   = (a[31] != b[31]) & (sub_w[31] != a[31]);
      end
      ALU_AND:  op_res = a & b;
      ALU_OR:   op_res = a | b;
      ALU_XOR:  op_res = a ^ b;
      ALU_SLT:  op_res = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: op_res = {31'd0, a < b};
      ALU_SLL, ALU_SRL, ALU_SRA: op_res = a;
      default:  op_res = '0;
    endcase
    op_z = (op_res == '0) & (alu_sel <= ALU_SRA);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      sh_val    <= '0;
      sh_left   <= 1'b0;
      sh_arith  <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      neg       <= 1'b0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (flush) begin
        cnt <= '0;
      end else if (start_shift) begin
        cnt      <= b[SHAMT_W-1:0];
        sh_val   <= a;
        sh_left  <= alu_sel == ALU_SLL;
        sh_arith <= alu_sel == ALU_SRA;
      end else if (busy) begin
        cnt    <= cnt - 1'b1;
        sh_val <= sh_nxt;
        if (last_step) begin
          result    <= sh_nxt;
          zero      <= sh_nxt == '0;
          neg       <= sh_nxt[31];
          carry     <= 1'b0;
          ovf       <= 1'b0;
          out_valid <= 1'b1;
        end
      end else if (accept) begin
        result    <= op_res;
        zero      <= op_z;
        neg       <= op_res[31];
        carry     <= op_c;
        ovf       <= op_v;
        out_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed vector table plus multi-cycle shift/flush/reset sequences
module tb_multicycle_alu;
  import multicycle_alu_pkg::*;
  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, out_valid, zero, neg, carry, ovf, busy;
  logic [3:0] alu_sel;
  logic [31:0] a, b, result;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  f;
  } vec_t;
  vec_t vecs[13];
  multicycle_alu dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_sel   (alu_sel),
    .a         (a),
    .b         (b),
    .result    (result),
    .out_valid (out_valid),
    .zero      (zero),
    .neg       (neg),
    .carry     (carry),
    .ovf       (ovf),
    .busy      (busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y);
    alu_sel  = s;
    a        = x;
    b        = y;
    in_valid = 1'b1;
  endtask
  function automatic logic [31:0] flags();
    return {28'd0, zero, neg, carry, ovf};
  endfunction
  initial begin
    int n;
    logic seen;
    vecs[0]  = '{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101};
    vecs[1]  = '{ALU_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 4'b1010};
    vecs[2]  = '{ALU_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 4'b0000};
    vecs[3]  = '{ALU_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 4'b1000};
    vecs[4]  = '{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010};
    vecs[5]  = '{ALU_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0100};
    vecs[6]  = '{ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011};
    vecs[7]  = '{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0100};
    vecs[8]  = '{ALU_OR,   32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000};
    vecs[9]  = '{ALU_XOR,  32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 4'b0000};
    vecs[10] = '{ALU_SLL,  32'h00000001, 32'h00000000, 32'h00000001, 4'b0000};
    vecs[11] = '{4'hF,     32'h00000000, 32'h00000000, 32'h00000000, 4'b0000};
    vecs[12] = '{ALU_SRA,  32'h80000000, 32'h00000020, 32'h80000000, 4'b0100};
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    alu_sel = '0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_result", result, 32'h0);
    chk("reset_flags", flags(), 32'h8);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].sel, vecs[i].a, vecs[i].b);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_result", i), result, vecs[i].res);
      chk($sformatf("vec%0d_flags", i), flags(), {28'd0, vecs[i].f});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk($sformatf("vec%0d_pulse_end", i), {31'd0, out_valid}, 32'd0);
      chk($sformatf("vec%0d_hold", i), result, vecs[i].res);
    end
    @(negedge clk);
    drive(ALU_SRA, 32'h80000000, 32'd4);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) drive(ALU_ADD, 32'd1, 32'd1);
      chk($sformatf("sra_busy_c%0d", c), {30'd0, busy, out_valid}, 32'b10);
    end
    @(negedge clk);
    chk("sra_out_valid", {30'd0, busy, out_valid}, 32'b01);
    chk("sra_result", result, 32'hF8000000);
    chk("sra_flags", flags(), 32'h4);
    @(negedge clk);
    in_valid = 1'b0;
    chk("held_add_out_valid", {31'd0, out_valid}, 32'd1);
    chk("held_add_result", result, 32'd2);
    @(negedge clk);
    drive(ALU_SLL, 32'd1, 32'd0);
    @(negedge clk);
    chk("sll0_c1", {30'd0, busy, out_valid}, 32'b01);
    chk("sll0_result", result, 32'd1);
    drive(ALU_XOR, 32'd3, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_c2", {30'd0, busy, out_valid}, 32'b01);
    chk("b2b_result", result, 32'd2);
    @(negedge clk);
    drive(ALU_SRL, 32'hF0, 32'd8);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_result", result, 32'd2);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("flush_no_late_pulse", {31'd0, seen}, 32'd0);
    drive(ALU_SRL, 32'hF0, 32'd2);
    @(negedge clk);
    in_valid = 1'b0;
    chk("final_flush_busy_c1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("final_flush_out_valid", {30'd0, busy, out_valid}, 32'd0);
    chk("final_flush_result", result, 32'd2);
    drive(ALU_ADD, 32'd7, 32'd7);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_drop_in_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_drop_result", result, 32'd2);
    @(negedge clk);
    drive(ALU_SRA, 32'h80000000, 32'd31);
    n = 0;
    seen = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!seen && n < 40) begin
      n++;
      if (out_valid) seen = 1'b1;
      else @(negedge clk);
    end
    chk("sra31_latency", n, 32);
    chk("sra31_result", result, 32'hFFFFFFFF);
    @(negedge clk);
    drive(ALU_SLL, 32'd1, 32'd10);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    flush = 1'b0;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_result", result, 32'd0);
    chk("rst_mid_flags", flags(), 32'h8);
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst, listed first among the ports.
REQ-002 Port clk: input, 1 bit, rising-edge clock for all state.
REQ-003 Port rst: input, 1 bit, synchronous active-high reset.
REQ-004 Port flush: input, 1 bit, pipeline flush; aborts any operation in progress.
REQ-005 Port in_valid: input, 1 bit, the operation on a, b and alu_sel is presented.
REQ-006 Port in_ready: output, 1 bit, the block can accept an operation this cycle.
REQ-007 Port alu_sel: input, 4 bits, ALU select code produced by the ALU_control stage (shared ALU_* constants).
REQ-008 Ports a and b: input, 32 bits each, operands (rs1 value; rs2 value or immediate).
REQ-009 Port result: output, 32 bits, registered result.
REQ-010 Port out_valid: output, 1 bit, one-cycle pulse marking that result and flags are new.
REQ-011 Ports zero, neg, carry, ovf: output, 1 bit each, registered flags of the last result.
REQ-012 Port busy: output, 1 bit, stall request to the hazard unit.

Function
REQ-013 An operation SHALL be accepted on a rising edge when in_valid=1, in_ready=1, flush=0 and rst=0.
REQ-014 in_ready SHALL equal ~busy, and busy SHALL be 1 exactly while the FSM is in SHIFT.
REQ-015 FSM states SHALL be IDLE and SHIFT.
- IDLE to SHIFT: shift accepted with shamt=b[4:0]>0.
- SHIFT to IDLE: at the edge where the remaining count is 1, or on flush.
REQ-016 Timing of non-shift operations:
- Covers ADD, SUB, AND, OR, XOR, SLT, SLTU, and shifts with shamt=0.
- result is valid and out_valid pulses in the cycle after acceptance (latency 1).
REQ-017 Timing of SLL, SRL and SRA with shamt k≥1:
- One bit is shifted per cycle.
- busy=1 in cycles 1..k after acceptance.
- out_valid=1 in cycle k+1.
REQ-018 SRA SHALL replicate a[31] on every step; SRL SHALL insert 0.
REQ-019 Arithmetic rules:
- ADD and SUB wrap modulo 2^32.
- carry: the carry-out for ADD; the no-borrow bit (a≥b unsigned) for SUB.
- ovf: signed overflow for ADD and SUB.
- SLT and SLTU return 32'd0 or 32'd1.
REQ-020 Flag rules:
- zero = (result==0); neg = result[31].
- carry and ovf SHALL be 0 for non-ADD/SUB operations.
- All four flags update only when out_valid pulses.
REQ-021 An undefined alu_sel code SHALL give result 0 and all flags 0, with latency 1.
REQ-022 result and the flags SHALL hold their values between out_valid pulses.
REQ-023 Back-to-back operation: a new operation MAY be accepted in the same cycle out_valid is high, with no bubble.
REQ-024 flush=1 SHALL:
- return the FSM to IDLE;
- suppress out_valid on the next edge;
- discard any same-cycle in_valid;
- leave result and the flags unchanged.
REQ-025 If flush and the final shift step coincide, flush SHALL win and no out_valid SHALL occur.
REQ-026 in_valid while busy=1 SHALL be ignored; upstream holds it.

Reset
REQ-027 On rst=1 at a clock edge, the block SHALL take these values:
- FSM to IDLE; shift counter = 0.
- result = 32'h0; zero = 1; neg = carry = ovf = 0.
- out_valid = 0; busy = 0.
REQ-028 rst SHALL take priority over flush and in_valid, including when asserted mid-shift.

Structure
REQ-029 The ALU_* select codes and the shamt width constant SHALL live in the shared defines package; the block SHALL NOT redefine them.
REQ-030 The block SHALL contain one sub-module, alu_shift_step: a combinational single-bit shifter (direction, arithmetic flag).
REQ-031 The FSM, counter, adder and flag logic SHALL stay in multicycle_alu.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- ADD a=32'h7FFFFFFF, b=1 -> cycle 1: result=32'h80000000, ovf=1, neg=1, carry=0, out_valid=1.
- SUB a=5, b=5 -> cycle 1: result=0, zero=1, carry=1; SLTU a=1, b=32'hFFFFFFFF -> result=1.
- SRA a=32'h80000000, b=4 -> busy in cycles 1..4; cycle 5: result=32'hF8000000, out_valid=1; in_valid during busy is ignored.
- SLL a=1, b=0 -> latency 1, result=1, busy never asserts; a second op accepted in the out_valid cycle produces its result the next cycle.
- SRL a=32'hF0, b=8 with flush in cycle 3 -> no out_valid, result unchanged, in_ready=1 in cycle 4.
- rst asserted mid-SHIFT -> next cycle: busy=0, result=0, zero=1, out_valid=0.
